bus_data_responder: RTL
=======================

Name: bus_data_responder

Overview:
- Memory-side responder for the microcontroller data bus.
- Accepts the address, write data and read/write strobe driven by the bus controller. Performs the access on an internal data RAM of 2^DEPTH_AW bytes and returns read data.
- Completes each access with a four-phase request/ready handshake and programmable wait states.
- Sits between the bus controller and the data memory space.

Parameters:
- DEPTH_AW, 5: RAM address width in bits (2^DEPTH_AW bytes); legal range 1..8.
- WAIT_STATES, 1: extra cycles inserted before the access; legal range 0..15.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous reset, active-low.
- i_Solicitud  input  1  access request; level, four-phase.
- i_Lectura_Escritura  input  1  1 = write, 0 = read.
- i_Bus_Direccion_Datos  input  8  byte address.
- i_Bus_Datos_E  input  8  write data from the bus controller.
- o_Bus_Datos_L  output  8  read data; registered.
- o_Listo  output  1  access complete; registered.
- o_Ocupado  output  1  high in every state except IDLE.
- o_Error  output  1  out-of-range access flag; 0 unless the macro is defined.

Behaviour:
- Reset (Rst=0, async):
  - State goes to IDLE.
  - o_Bus_Datos_L=0x00, o_Listo=0, o_Ocupado=0, o_Error=0.
  - Wait counter=0; all RAM bytes cleared to 0x00.
- Reset mid-transaction: abort immediately. A write not yet in ACCESS is never performed.
- FSM states: IDLE, WAIT, ACCESS, ACK.
- IDLE:
  - On the edge sampling i_Solicitud=1, capture address, write data and R/W into internal registers.
  - Load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: decrement counter each cycle; go to ACCESS on the edge where counter==1.
- ACCESS, one cycle, then go to ACK:
  - Write: RAM[addr] <= captured data.
  - Read: o_Bus_Datos_L <= RAM[addr].
- ACK:
  - o_Listo=1; remain in ACK while i_Solicitud=1.
  - Go to IDLE on the edge sampling i_Solicitud=0; o_Listo falls on that same edge.
- Latency: request sampled at edge 0 → o_Listo high after edge WAIT_STATES+2. Read data is valid no later than o_Listo.
- Inputs are ignored after capture; changes to address, data or R/W mid-transaction have no effect.
- A held request never retriggers. A new access needs i_Solicitud low for at least one IDLE sample, then high again.
- o_Bus_Datos_L holds the last read value across writes and idle periods.
- Address decode, default build: only the low DEPTH_AW bits are used; upper bits alias (wrap-around).
- Read-after-write to the same address in back-to-back transactions returns the new data.

Optional Feature:
- Macro: BUS_RESP_RANGE_CHECK_EN.
- Defined:
  - If any captured address bit at or above DEPTH_AW is 1, ACCESS suppresses the write and a read loads 0x00.
  - o_Error is set with o_Listo and cleared with o_Listo. Aliasing is disabled.
- Undefined: o_Error is tied to 0 and upper address bits are ignored.

Test Plan:
- Write, then read (WAIT_STATES=1):
  - Write 0x03 to address 0x0F → o_Listo rises 3 edges after request.
  - Read address 0x0F → o_Bus_Datos_L=0x03.
- Read of unwritten address after reset: address 0x01 → 0x00, o_Error=0.
- WAIT_STATES=0:
  - Write 0x01 to 0x0E → o_Listo after 2 edges.
  - Hold i_Solicitud high for 5 extra cycles → exactly one write, o_Listo stays 1, o_Ocupado=1.
  - Drop request → IDLE next edge.
- DEPTH_AW=5, address 0x2F:
  - Macro undefined: write 0xAA, then read 0x0F → 0xAA.
  - Macro defined: write 0xAA → o_Error=1, RAM[0x0F] unchanged; read 0x2F → 0x00 with o_Error=1.
- Reset mid-write (WAIT_STATES=3):
  - Assert Rst=0 during WAIT → o_Listo=0, o_Ocupado=0 immediately.
  - Read of the target address afterwards → 0x00.
- Mid-transaction input change: change address and data during WAIT → the captured address and data are used.

Source files
------------

// File: rtl/bus_data_responder.sv
// bus_data_responder: memory-side responder for the microcontroller data bus.
// Captures address / write data / direction on a four-phase request, waits
// WAIT_STATES cycles, performs the access on a 2^DEPTH_AW byte RAM and
// acknowledges with o_Listo until the request is withdrawn.
// Optional feature macro: BUS_RESP_RANGE_CHECK_EN. When it is defined,
// out-of-range addresses are flagged on o_Error and the access is suppressed.
// When it is undefined, upper address bits alias onto the RAM.
module bus_data_responder #(
  parameter int DEPTH_AW    = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Solicitud,
  input  logic       i_Lectura_Escritura,
  input  logic [7:0] i_Bus_Direccion_Datos,
  input  logic [7:0] i_Bus_Datos_E,
  output logic [7:0] o_Bus_Datos_L,
  output logic       o_Listo,
  output logic       o_Ocupado,
  output logic       o_Error
);

  localparam int         DEPTH     = 1 << DEPTH_AW;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  capture_s;
  logic [3:0]            cnt_r;
  logic [7:0]            addr_r;
  logic [7:0]            wdata_r;
  logic                  write_r;
  logic [7:0]            ram_r [DEPTH];
  logic [7:0]            rdata_r;
  logic                  listo_r;
  logic [DEPTH_AW-1:0]   idx_s;
  logic [7:0]            addr_hi_s;
  logic                  in_range_s;

  // RAM index is always the low address bits; the remainder is the range tag.
  assign idx_s     = addr_r[DEPTH_AW-1:0];
  assign addr_hi_s = addr_r >> DEPTH_AW;

`ifdef BUS_RESP_RANGE_CHECK_EN
  logic error_r;

  assign in_range_s = (addr_hi_s == 8'd0);
  assign o_Error    = error_r;

  // Error flag rises and falls together with o_Listo for out-of-range accesses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      error_r <= 1'b0;
    end else begin
      error_r <= (state_r == ST_ACK) && i_Solicitud && !in_range_s;
    end
  end
`else
  logic unused_addr_hi_s;

  // Upper address bits alias onto the RAM, so every access is in range.
  assign unused_addr_hi_s = |addr_hi_s;
  assign in_range_s       = 1'b1;
  assign o_Error          = 1'b0;
`endif

  assign o_Bus_Datos_L = rdata_r;
  assign o_Listo       = listo_r;
  assign o_Ocupado     = (state_r != ST_IDLE);

  // Next-state decode for the IDLE -> WAIT -> ACCESS -> ACK handshake.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_Solicitud) begin
          capture_s = 1'b1;
          if (WAIT_LOAD != 4'd0) begin
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_ACCESS;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        next_state_s = ST_ACK;
      end
      ST_ACK: begin
        if (!i_Solicitud) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ACK;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture and wait-state counter; inputs are ignored after capture.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_r   <= 4'd0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      write_r <= 1'b0;
    end else if (capture_s) begin
      cnt_r   <= WAIT_LOAD;
      addr_r  <= i_Bus_Direccion_Datos;
      wdata_r <= i_Bus_Datos_E;
      write_r <= i_Lectura_Escritura;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Data RAM: cleared by reset, written only in ACCESS.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_r[i] <= 8'h00;
      end
    end else if ((state_r == ST_ACCESS) && write_r && in_range_s) begin
      ram_r[idx_s] <= wdata_r;
    end
  end

  // Read data register; holds the last read value across writes and idle time.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdata_r <= 8'h00;
    end else if ((state_r == ST_ACCESS) && !write_r) begin
      rdata_r <= in_range_s ? ram_r[idx_s] : 8'h00;
    end
  end

  // Ready is raised while the acknowledge is held and drops as the request goes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      listo_r <= 1'b0;
    end else begin
      listo_r <= (state_r == ST_ACK) && i_Solicitud;
    end
  end

endmodule
